// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver, the scan-code decoder and its consumer.
// The decoder takes the slave view; the receiver/consumer side takes the master view.
interface ps2_key_decoder_if #(
   parameter int DATA_W = 8
);
   logic              rx_done_tick;
   logic [DATA_W-1:0] dout;
   logic              key_rd;
   logic              clr_ovf;
   logic              key_valid;
   logic [DATA_W-1:0] key_code;
   logic              key_ext;
   logic              key_break;
   logic              fifo_full;
   logic              overflow;

   modport master (
      output rx_done_tick, dout, key_rd, clr_ovf,
      input  key_valid, key_code, key_ext, key_break, fifo_full, overflow
   );

   modport slave (
      input  rx_done_tick, dout, key_rd, clr_ovf,
      output key_valid, key_code, key_ext, key_break, fifo_full, overflow
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: strips E0/F0 prefixes, optionally filters typematic repeats,
// and queues qualified make/break events in a first-word-fall-through FIFO.
module ps2_key_decoder #(
   parameter int                DATA_W        = 8,
   parameter int                FIFO_DEPTH    = 4,
   parameter logic [DATA_W-1:0] BREAK_CODE    = 8'hF0,
   parameter logic [DATA_W-1:0] EXT_CODE      = 8'hE0,
   parameter int                MODE          = 2,
   parameter int                REPEAT_FILTER = 1
) (
   input logic                clk,
   input logic                reset,
   ps2_key_decoder_if.slave   bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_W + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } state_t;

   state_t            state_q, state_d;
   logic              held_valid_q, held_valid_d;
   logic              held_ext_q, held_ext_d;
   logic [DATA_W-1:0] held_code_q, held_code_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d;
   logic              ovf_q, ovf_d;
   logic [EW-1:0]     mem_q [FIFO_DEPTH];

   logic              evt_valid, evt_ext, evt_brk;
   logic              held_match, drop, mode_ok, wr_req;
   logic              empty, full_now, rd_en, wr_en;
   logic [EW-1:0]     head;

   always_comb begin
      state_d   = state_q;
      evt_valid = 1'b0;
      evt_ext   = 1'b0;
      evt_brk   = 1'b0;
      if (bus.rx_done_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.dout == EXT_CODE)        state_d = ST_EXT;
               else if (bus.dout == BREAK_CODE) state_d = ST_BRK;
               else                             evt_valid = 1'b1;
            end
            ST_EXT: begin
               if (bus.dout == BREAK_CODE) begin
                  state_d = ST_EXT_BRK;
               end else if (bus.dout != EXT_CODE) begin
                  evt_valid = 1'b1;
                  evt_ext   = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (bus.dout != BREAK_CODE) begin
                  evt_valid = 1'b1;
                  evt_brk   = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            default: begin
               if (bus.dout != BREAK_CODE) begin
                  evt_valid = 1'b1;
                  evt_ext   = 1'b1;
                  evt_brk   = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         endcase
      end
   end

   // The held key tracks every decoded event, even ones the mode gate later discards.
   always_comb begin
      held_valid_d = held_valid_q;
      held_ext_d   = held_ext_q;
      held_code_d  = held_code_q;
      drop         = 1'b0;
      held_match   = held_valid_q && (held_ext_q == evt_ext) && (held_code_q == bus.dout);
      if ((REPEAT_FILTER != 0) && evt_valid) begin
         if (!evt_brk) begin
            if (held_match) begin
               drop = 1'b1;
            end else begin
               held_valid_d = 1'b1;
               held_ext_d   = evt_ext;
               held_code_d  = bus.dout;
            end
         end else if (held_match) begin
            held_valid_d = 1'b0;
         end
      end
      mode_ok = (MODE == 2) || ((MODE == 0) && evt_brk) || ((MODE == 1) && !evt_brk);
      wr_req  = evt_valid && !drop && mode_ok;
   end

   // A pop frees a slot in the same cycle, so a full queue still accepts a write alongside it.
   always_comb begin
      empty    = (count_q == '0);
      full_now = (count_q == CW'(FIFO_DEPTH));
      rd_en    = bus.key_rd && !empty;
      wr_en    = wr_req && (!full_now || rd_en);
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_en);
      full_d   = (count_d == CW'(FIFO_DEPTH));
      ovf_d    = (ovf_q && !bus.clr_ovf) || (wr_req && !wr_en);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         held_valid_q <= 1'b0;
         held_ext_q   <= 1'b0;
         held_code_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         held_valid_q <= held_valid_d;
         held_ext_q   <= held_ext_d;
         held_code_q  <= held_code_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         ovf_q        <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {evt_ext, evt_brk, bus.dout};
   end

   assign head          = mem_q[rd_ptr_q];
   assign bus.key_valid = !empty;
   assign bus.key_code  = empty ? '0 : head[DATA_W-1:0];
   assign bus.key_ext   = !empty && head[DATA_W+1];
   assign bus.key_break = !empty && head[DATA_W];
   assign bus.fifo_full = full_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: four decoder configurations share one stimulus stream and are
// checked by directed scenarios plus a randomized run against a queue-based reference model.
module tb_ps2_key_decoder;

   localparam int N = 4;
   // dut0: MODE2/no filter, dut1: MODE2/filter, dut2: MODE0/filter, dut3: MODE1/no filter
   localparam logic [7:0] MODES_P = {2'd1, 2'd0, 2'd2, 2'd2};
   localparam logic [3:0] RF_P    = 4'b0110;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       drv_rx;
   logic [7:0] drv_dout;
   logic       drv_rd;
   logic       drv_clr;
   logic [12:0] obs [N];

   int compares = 0;
   int fails    = 0;

   always #5 clk = ~clk;

   ps2_key_decoder_if #(.DATA_W(8)) bus [N] ();

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_dut
         assign bus[g].rx_done_tick = drv_rx;
         assign bus[g].dout         = drv_dout;
         assign bus[g].key_rd       = drv_rd;
         assign bus[g].clr_ovf      = drv_clr;
         assign obs[g] = {bus[g].key_valid, bus[g].key_ext, bus[g].key_break,
                          bus[g].fifo_full, bus[g].overflow, bus[g].key_code};
         ps2_key_decoder #(
            .DATA_W(8), .FIFO_DEPTH(4), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0),
            .MODE(int'(MODES_P[2*g +: 2])), .REPEAT_FILTER(int'(RF_P[g]))
         ) dut (
            .clk(clk), .reset(rst_n), .bus(bus[g])
         );
      end
   endgenerate

   // Reference model: prefix flags, held key, and an array-backed queue per configuration.
   logic       m_ext [N];
   logic       m_brk [N];
   logic       m_hv  [N];
   logic       m_he  [N];
   logic [7:0] m_hc  [N];
   logic [9:0] m_q   [N][4];
   int         m_cnt [N];
   logic       m_ovf [N];

   function automatic logic [12:0] pack(input logic v, input logic e, input logic b,
                                        input logic f, input logic o, input logic [7:0] c);
      return {v, e, b, f, o, c};
   endfunction

   function automatic logic [12:0] model_out(input int d);
      if (m_cnt[d] == 0) return pack(1'b0, 1'b0, 1'b0, 1'b0, m_ovf[d], 8'h00);
      return pack(1'b1, m_q[d][0][9], m_q[d][0][8], m_cnt[d] == 4, m_ovf[d], m_q[d][0][7:0]);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < N; d++) begin
         m_ext[d] = 1'b0; m_brk[d] = 1'b0; m_hv[d] = 1'b0; m_he[d] = 1'b0;
         m_hc[d] = 8'h00; m_cnt[d] = 0; m_ovf[d] = 1'b0;
      end
   endtask

   task automatic model_edge(input logic rx, input logic [7:0] b, input logic rd, input logic clr);
      for (int d = 0; d < N; d++) begin
         logic ev = 1'b0, e = 1'b0, k = 1'b0, keep, same, lost = 1'b0;
         int   mode = int'(MODES_P[2*d +: 2]);
         if (rx) begin
            if (b == 8'hE0 && !m_brk[d]) m_ext[d] = 1'b1;
            else if (b == 8'hF0)         m_brk[d] = 1'b1;
            else begin
               ev = 1'b1; e = m_ext[d]; k = m_brk[d];
               m_ext[d] = 1'b0; m_brk[d] = 1'b0;
            end
         end
         keep = ev;
         if (ev && RF_P[d]) begin
            same = m_hv[d] && (m_he[d] == e) && (m_hc[d] == b);
            if (!k) begin
               if (same) keep = 1'b0;
               else begin m_hv[d] = 1'b1; m_he[d] = e; m_hc[d] = b; end
            end else if (same) m_hv[d] = 1'b0;
         end
         if (keep && !(mode == 2 || (mode == 0 && k) || (mode == 1 && !k))) keep = 1'b0;
         if (rd && m_cnt[d] > 0) begin
            for (int i = 0; i < 3; i++) m_q[d][i] = m_q[d][i+1];
            m_cnt[d]--;
         end
         if (keep) begin
            if (m_cnt[d] < 4) begin m_q[d][m_cnt[d]] = {e, k, b}; m_cnt[d]++; end
            else lost = 1'b1;
         end
         if (clr)  m_ovf[d] = 1'b0;
         if (lost) m_ovf[d] = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic rx, input logic [7:0] b, input logic rd, input logic clr);
      drv_rx = rx; drv_dout = b; drv_rd = rd; drv_clr = clr;
      @(posedge clk);
      model_edge(rx, b, rd, clr);
      #1;
      drv_rx = 1'b0; drv_dout = 8'h00; drv_rd = 1'b0; drv_clr = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      applyStimulus(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic pop();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < N; d++) begin
         compares++;
         if (obs[d] !== 13'h0) begin
            fails++;
            $display("[TB] FAIL reset_outputs dut%0d got=%h exp=%h", d, obs[d], 13'h0);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_make_break();
      do_reset();
      compares++;
      if (obs[0] !== pack(0,0,0,0,0,8'h00)) begin
         fails++; $display("[TB] FAIL mb_idle got=%h exp=%h", obs[0], pack(0,0,0,0,0,8'h00));
      end
      send(8'h1C);
      compares++;
      if (obs[0] !== pack(1,0,0,0,0,8'h1C)) begin
         fails++; $display("[TB] FAIL mb_make_latency got=%h exp=%h", obs[0], pack(1,0,0,0,0,8'h1C));
      end
      send(8'hF0);
      send(8'h1C);
      compares++;
      if (obs[2] !== pack(1,0,1,0,0,8'h1C)) begin
         fails++; $display("[TB] FAIL mb_mode0_head got=%h exp=%h", obs[2], pack(1,0,1,0,0,8'h1C));
      end
      compares++;
      if (obs[3] !== pack(1,0,0,0,0,8'h1C)) begin
         fails++; $display("[TB] FAIL mb_mode1_head got=%h exp=%h", obs[3], pack(1,0,0,0,0,8'h1C));
      end
      pop();
      compares++;
      if (obs[0] !== pack(1,0,1,0,0,8'h1C)) begin
         fails++; $display("[TB] FAIL mb_break got=%h exp=%h", obs[0], pack(1,0,1,0,0,8'h1C));
      end
      compares++;
      if (obs[3] !== pack(0,0,0,0,0,8'h00)) begin
         fails++; $display("[TB] FAIL mb_mode1_empty got=%h exp=%h", obs[3], pack(0,0,0,0,0,8'h00));
      end
      pop();
      compares++;
      if (obs[0] !== pack(0,0,0,0,0,8'h00)) begin
         fails++; $display("[TB] FAIL mb_drained got=%h exp=%h", obs[0], pack(0,0,0,0,0,8'h00));
      end
   endtask

   task automatic test_extended();
      do_reset();
      send(8'hE0);
      compares++;
      if (obs[0] !== pack(0,0,0,0,0,8'h00)) begin
         fails++; $display("[TB] FAIL ext_prefix_no_entry got=%h exp=%h", obs[0], pack(0,0,0,0,0,8'h00));
      end
      send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      compares++;
      if (obs[0] !== pack(1,1,0,0,0,8'h75)) begin
         fails++; $display("[TB] FAIL ext_make got=%h exp=%h", obs[0], pack(1,1,0,0,0,8'h75));
      end
      pop();
      compares++;
      if (obs[0] !== pack(1,1,1,0,0,8'h75)) begin
         fails++; $display("[TB] FAIL ext_break got=%h exp=%h", obs[0], pack(1,1,1,0,0,8'h75));
      end
   endtask

   task automatic test_repeat_filter();
      logic [12:0] exp_seq [4];
      exp_seq[0] = pack(1,0,0,0,0,8'h1C);
      exp_seq[1] = pack(1,0,1,0,0,8'h1C);
      exp_seq[2] = pack(1,0,0,0,0,8'h1C);
      exp_seq[3] = pack(0,0,0,0,0,8'h00);
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
      compares++;
      if (obs[0] !== pack(1,0,0,1,1,8'h1C)) begin
         fails++; $display("[TB] FAIL rf_unfiltered_ovf got=%h exp=%h", obs[0], pack(1,0,0,1,1,8'h1C));
      end
      for (int i = 0; i < 4; i++) begin
         compares++;
         if (obs[1] !== exp_seq[i]) begin
            fails++; $display("[TB] FAIL rf_entry%0d got=%h exp=%h", i, obs[1], exp_seq[i]);
         end
         pop();
      end
   endtask

   task automatic test_mode0();
      do_reset();
      send(8'h1C); send(8'h32); send(8'hF0);
      compares++;
      if (obs[2] !== pack(0,0,0,0,0,8'h00)) begin
         fails++; $display("[TB] FAIL m0_no_makes got=%h exp=%h", obs[2], pack(0,0,0,0,0,8'h00));
      end
      send(8'h1C); send(8'hF0); send(8'h1C);
      for (int i = 0; i < 2; i++) begin
         compares++;
         if (obs[2] !== pack(1,0,1,0,0,8'h1C)) begin
            fails++; $display("[TB] FAIL m0_break%0d got=%h exp=%h", i, obs[2], pack(1,0,1,0,0,8'h1C));
         end
         pop();
      end
      compares++;
      if (obs[2] !== pack(0,0,0,0,0,8'h00)) begin
         fails++; $display("[TB] FAIL m0_drained got=%h exp=%h", obs[2], pack(0,0,0,0,0,8'h00));
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] rest [4];
      rest[0] = 8'h16; rest[1] = 8'h1D; rest[2] = 8'h1E; rest[3] = 8'h2D;
      do_reset();
      send(8'h15); send(8'h16); send(8'h1D);
      compares++;
      if (obs[0] !== pack(1,0,0,0,0,8'h15)) begin
         fails++; $display("[TB] FAIL ff_three got=%h exp=%h", obs[0], pack(1,0,0,0,0,8'h15));
      end
      send(8'h1E);
      compares++;
      if (obs[0] !== pack(1,0,0,1,0,8'h15)) begin
         fails++; $display("[TB] FAIL ff_full got=%h exp=%h", obs[0], pack(1,0,0,1,0,8'h15));
      end
      send(8'h24);
      compares++;
      if (obs[0] !== pack(1,0,0,1,1,8'h15)) begin
         fails++; $display("[TB] FAIL ff_overflow got=%h exp=%h", obs[0], pack(1,0,0,1,1,8'h15));
      end
      applyStimulus(1'b1, 8'h2D, 1'b1, 1'b0);
      compares++;
      if (obs[0] !== pack(1,0,0,1,1,8'h16)) begin
         fails++; $display("[TB] FAIL ff_write_with_pop got=%h exp=%h", obs[0], pack(1,0,0,1,1,8'h16));
      end
      applyStimulus(1'b1, 8'h2E, 1'b0, 1'b1);
      compares++;
      if (obs[0] !== pack(1,0,0,1,1,8'h16)) begin
         fails++; $display("[TB] FAIL ff_set_wins got=%h exp=%h", obs[0], pack(1,0,0,1,1,8'h16));
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      compares++;
      if (obs[0] !== pack(1,0,0,1,0,8'h16)) begin
         fails++; $display("[TB] FAIL ff_clr_ovf got=%h exp=%h", obs[0], pack(1,0,0,1,0,8'h16));
      end
      for (int i = 1; i < 4; i++) begin
         pop();
         compares++;
         if (obs[0] !== pack(1,0,0,0,0,rest[i])) begin
            fails++; $display("[TB] FAIL ff_order%0d got=%h exp=%h", i, obs[0], pack(1,0,0,0,0,rest[i]));
         end
      end
      pop();
      pop();
      compares++;
      if (obs[0] !== pack(0,0,0,0,0,8'h00)) begin
         fails++; $display("[TB] FAIL ff_pop_empty got=%h exp=%h", obs[0], pack(0,0,0,0,0,8'h00));
      end
   endtask

   task automatic test_reset_mid_prefix();
      do_reset();
      send(8'h1C); send(8'hE0); send(8'hF0);
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < N; d++) begin
         compares++;
         if (obs[d] !== 13'h0) begin
            fails++; $display("[TB] FAIL rst_async dut%0d got=%h exp=%h", d, obs[d], 13'h0);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(8'h75);
      compares++;
      if (obs[0] !== pack(1,0,0,0,0,8'h75)) begin
         fails++; $display("[TB] FAIL rst_prefix_dropped got=%h exp=%h", obs[0], pack(1,0,0,0,0,8'h75));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pool [6];
      pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C;
      pool[3] = 8'h32; pool[4] = 8'h75; pool[5] = 8'hF0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic       rx  = ($urandom_range(0, 9) < 8);
         logic [7:0] b   = pool[$urandom_range(0, 5)];
         logic       rd  = ($urandom_range(0, 2) == 0);
         logic       clr = ($urandom_range(0, 15) == 0);
         applyStimulus(rx, b, rd, clr);
         for (int d = 0; d < N; d++) begin
            compares++;
            if (obs[d] !== model_out(d)) begin
               fails++;
               $display("[TB] FAIL rand_c%0d dut%0d got=%h exp=%h", c, d, obs[d], model_out(d));
            end
         end
      end
   endtask

   initial begin
      drv_rx = 1'b0; drv_dout = 8'h00; drv_rd = 1'b0; drv_clr = 1'b0;
      test_reset();
      test_make_break();
      test_extended();
      test_repeat_filter();
      test_mode0();
      test_fifo_full();
      test_reset_mid_prefix();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
